// File: rtl/btn_cond_pkg.sv
// Shared definitions for the pushbutton conditioner: repeat-FSM state encoding
// and the default / reduced-simulation cycle constants.
package btn_cond_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } rep_state_t;

   localparam int DEF_DB_CYCLES   = 500_000;
   localparam int DEF_HOLD_CYCLES = 25_000_000;
   localparam int DEF_REP_CYCLES  = 5_000_000;
   localparam int DEF_CNT_W       = 32;

   // Short values so a simulation sees debounce and repeat behaviour in a few hundred clocks
   localparam int SIM_DB_CYCLES   = 4;
   localparam int SIM_HOLD_CYCLES = 20;
   localparam int SIM_REP_CYCLES  = 8;

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchronizer, debounce counter and (with
// BTN_AUTOREPEAT_EN defined) the hold/repeat FSM that adds extra press pulses.
module btn_channel
   import btn_cond_pkg::*;
#(
   parameter int DB_CYCLES   = DEF_DB_CYCLES,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int REP_CYCLES  = DEF_REP_CYCLES,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic pb_n,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

   logic             sync_meta;
   logic             sync_q;
   logic [CNT_W-1:0] db_cnt;
   logic             db_state;
   logic             db_flip;
   logic             accept_press;
   logic             accept_release;
   logic             repeat_fire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_meta <= 1'b0;
         sync_q    <= 1'b0;
      end else begin
         sync_meta <= ~pb_n;
         sync_q    <= sync_meta;
      end
   end

   // Any sample that agrees with the accepted level restarts the stability count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_cnt   <= '0;
         db_state <= 1'b0;
      end else if (sync_q == db_state) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
         db_cnt   <= '0;
         db_state <= sync_q;
      end else begin
         db_cnt <= db_cnt + CNT_W'(1);
      end
   end

   assign db_flip        = (sync_q != db_state) && (db_cnt == DB_LAST);
   assign accept_press   = db_flip &  sync_q;
   assign accept_release = db_flip & ~sync_q;

`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYCLES - 1);

   rep_state_t       state;
   rep_state_t       state_nxt;
   logic [CNT_W-1:0] hold_cnt;
   logic [CNT_W-1:0] hold_cnt_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_cnt_nxt;
      end
   end

   // Release is tested before the terminal counts so it wins a same-cycle repeat
   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      repeat_fire  = 1'b0;
      case (state)
         IDLE: begin
            hold_cnt_nxt = '0;
            if (accept_press) state_nxt = HOLD;
         end
         HOLD: begin
            if (accept_release) begin
               state_nxt    = IDLE;
               hold_cnt_nxt = '0;
            end else if (hold_cnt == HOLD_LAST) begin
               state_nxt    = REPEAT;
               hold_cnt_nxt = '0;
               repeat_fire  = 1'b1;
            end else begin
               hold_cnt_nxt = hold_cnt + CNT_W'(1);
            end
         end
         REPEAT: begin
            if (accept_release) begin
               state_nxt    = IDLE;
               hold_cnt_nxt = '0;
            end else if (hold_cnt == REP_LAST) begin
               hold_cnt_nxt = '0;
               repeat_fire  = 1'b1;
            end else begin
               hold_cnt_nxt = hold_cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt    = IDLE;
            hold_cnt_nxt = '0;
         end
      endcase
   end
`else
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = ^{32'(HOLD_CYCLES), 32'(REP_CYCLES)};
   assign repeat_fire       = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         press_pulse   <= accept_press | repeat_fire;
         release_pulse <= accept_release;
      end
   end

   assign pressed = db_state;

endmodule

// File: rtl/button_conditioner.sv
// N independent active-low pushbuttons turned into clean levels and press/release
// pulses; auto-repeat is built only when BTN_AUTOREPEAT_EN is defined.
module button_conditioner
   import btn_cond_pkg::*;
#(
   parameter int N_BTN       = 2,
   parameter int DB_CYCLES   = DEF_DB_CYCLES,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int REP_CYCLES  = DEF_REP_CYCLES,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] pb_n,
   output logic [N_BTN-1:0] pressed,
   output logic [N_BTN-1:0] press_pulse,
   output logic [N_BTN-1:0] release_pulse
);

   for (genvar g = 0; g < N_BTN; g++) begin : g_chan
      btn_channel #(
         .DB_CYCLES   (DB_CYCLES),
         .HOLD_CYCLES (HOLD_CYCLES),
         .REP_CYCLES  (REP_CYCLES),
         .CNT_W       (CNT_W)
      ) u_chan (
         .clk           (clk),
         .rst           (rst),
         .pb_n          (pb_n[g]),
         .pressed       (pressed[g]),
         .press_pulse   (press_pulse[g]),
         .release_pulse (release_pulse[g])
      );
   end

endmodule
